// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch vs loader/debug port, starvation-bounded.
// Define IMEM_ARB_BOOT_EN to add the BOOT phase (loader-only until boot_done).
module imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              pc_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              boot_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

`ifdef IMEM_ARB_BOOT_EN
  localparam state_t RST_ST = BOOT;
`else
  localparam state_t RST_ST = RUN;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        starve_cnt;
  logic              starve_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_ST;
    else      state <= state_nxt;
  end

`ifdef IMEM_ARB_BOOT_EN
  always_comb begin
    state_nxt = state;
    if (state == BOOT && boot_done) state_nxt = RUN;
  end
`else
  logic unused_boot_done;
  assign unused_boot_done = boot_done;

  always_comb begin
    state_nxt = state;
  end
`endif

  assign starve_hit = (starve_cnt == SMAX);

  // Grants are held off while reset is asserted so the port stays quiet.
  always_comb begin
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    pc_stall = 1'b0;
    if (rst) begin
      unique case (1'b1)
        state == BOOT: begin
          l_gnt    = l_req;
          pc_stall = 1'b1;
        end
        state == RUN: begin
          l_gnt    = l_req & (~f_req | starve_hit);
          f_gnt    = f_req & ~l_gnt;
          pc_stall = f_req & ~f_gnt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
    end else if (state != RUN || l_gnt || !l_req) begin
      starve_cnt <= 4'd0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : addr_q);
  assign mem_wdata = l_gnt ? l_wdata : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      f_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      f_rvalid <= f_gnt;
      l_rvalid <= l_gnt & ~l_we;
    end
  end

  assign f_rdata = mem_rdata;
  assign l_rdata = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a small synchronous memory model.
// Follows IMEM_ARB_BOOT_EN the same way the design does.
module tb_imem_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_gnt, f_rvalid, pc_stall;
  logic [31:0] f_rdata;
  logic        l_req = 1'b0;
  logic        l_we = 1'b0;
  logic [31:0] l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        boot_done = 1'b0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] fq[$];
  logic [31:0] lq[$];
  logic [31:0] shadow[16];
  logic [31:0] mem[16];
  logic        loaded = 1'b0;
  logic [31:0] fexp, lexp;

  imem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .pc_stall(pc_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  always @(negedge clk) begin
    if (f_rvalid) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL f_rvalid_unexpected got 1 want 0");
      end else begin
        fexp = fq.pop_front();
        if (f_rdata !== fexp) begin
          errors++;
          $display("FAIL f_rdata got %h want %h", f_rdata, fexp);
        end
      end
    end
    if (l_rvalid) begin
      checks++;
      if (lq.size() == 0) begin
        errors++;
        $display("FAIL l_rvalid_unexpected got 1 want 0");
      end else begin
        lexp = lq.pop_front();
        if (l_rdata !== lexp) begin
          errors++;
          $display("FAIL l_rdata got %h want %h", l_rdata, lexp);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; boot_done = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) shadow[i] = 32'hA000_0000 + i;
    rst = 1'b0;
    idle();
    tick(); tick();
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_f_rvalid got %b want 0", f_rvalid);
    end
    checks++;
    if (l_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_l_rvalid got %b want 0", l_rvalid);
    end
    checks++;
    if (mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_first_fetch;
    f_req = 1'b1; f_addr = 32'h0; boot_done = 1'b1;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1) begin
      errors++; $display("FAIL first_f_gnt got %b want 1", f_gnt);
    end
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL first_pc_stall got %b want 0", pc_stall);
    end
    fq.push_back(shadow[0]);
    tick();
    idle();
    tick();
  endtask

  task automatic test_loader_write;
    logic [31:0] wa[2];
    logic [31:0] wd[2];
    logic        stall_exp;
    wa[0] = 32'h0; wd[0] = 32'h0000_0013;
    wa[1] = 32'h4; wd[1] = 32'h0040_0093;
`ifdef IMEM_ARB_BOOT_EN
    stall_exp = 1'b1;
    f_req = 1'b1; f_addr = 32'h8;
`else
    stall_exp = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = wa[i]; l_wdata = wd[i];
      @(negedge clk);
      checks++;
      if (l_gnt !== 1'b1 || f_gnt !== 1'b0) begin
        errors++;
        $display("FAIL wr_gnt got l=%b f=%b want l=1 f=0", l_gnt, f_gnt);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
        errors++;
        $display("FAIL wr_en_we got %b%b want 11", mem_en, mem_we);
      end
      checks++;
      if (mem_addr !== wa[i] || mem_wdata !== wd[i]) begin
        errors++;
        $display("FAIL wr_bus got %h/%h want %h/%h",
                 mem_addr, mem_wdata, wa[i], wd[i]);
      end
      checks++;
      if (pc_stall !== stall_exp) begin
        errors++;
        $display("FAIL wr_pc_stall got %b want %b", pc_stall, stall_exp);
      end
      shadow[wa[i][5:2]] = wd[i];
      tick();
    end
    idle();
    tick();
  endtask

`ifdef IMEM_ARB_BOOT_EN
  task automatic test_boot;
    boot_done = 1'b1;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0;
    f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk);
    checks++;
    if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL boot_edge got l=%b f=%b s=%b want 1 0 1",
               l_gnt, f_gnt, pc_stall);
    end
    lq.push_back(shadow[0]);
    tick();
    boot_done = 1'b0; l_req = 1'b0;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1 || pc_stall !== 1'b0 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL run_fetch got f=%b s=%b a=%h want 1 0 4",
               f_gnt, pc_stall, mem_addr);
    end
    fq.push_back(shadow[1]);
    tick();
    boot_done = 1'b1; l_req = 1'b1; l_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin
      errors++;
      $display("FAIL boot_in_run got f=%b l=%b want 1 0", f_gnt, l_gnt);
    end
    fq.push_back(shadow[1]);
    tick();
    idle();
    tick();
  endtask
`endif

  task automatic test_starve;
    logic exp_l;
    logic [31:0] exp_a;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8; f_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (l_gnt !== 1'b1 || mem_addr !== 32'h8) begin
        errors++;
        $display("FAIL lonly_%0d got g=%b a=%h want 1 8", i, l_gnt, mem_addr);
      end
      lq.push_back(shadow[2]);
      tick();
    end
    f_req = 1'b1; f_addr = 32'hC;
    for (int i = 0; i < 2 * (SMAX + 1); i++) begin
      exp_l = ((i % (SMAX + 1)) == SMAX);
      exp_a = exp_l ? 32'h8 : 32'hC;
      @(negedge clk);
      checks++;
      if (l_gnt !== exp_l || f_gnt !== !exp_l || pc_stall !== exp_l) begin
        errors++;
        $display("FAIL starve_%0d got l=%b f=%b s=%b want l=%b",
                 i, l_gnt, f_gnt, pc_stall, exp_l);
      end
      checks++;
      if (mem_addr !== exp_a) begin
        errors++;
        $display("FAIL starve_addr_%0d got %h want %h", i, mem_addr, exp_a);
      end
      if (exp_l) lq.push_back(shadow[2]);
      else       fq.push_back(shadow[3]);
      tick();
    end
    idle();
  endtask

  task automatic test_hold;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL hold_en got %b%b want 00", mem_en, mem_we);
    end
    checks++;
    if (mem_addr !== 32'h8 || mem_wdata !== 32'h0040_0093) begin
      errors++;
      $display("FAIL hold_bus got %h/%h want 8/00400093",
               mem_addr, mem_wdata);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    f_req = 1'b1; f_addr = 32'h0;
    @(negedge clk);
    checks++;
    if (f_gnt !== 1'b1) begin
      errors++; $display("FAIL mid_f_gnt got %b want 1", f_gnt);
    end
    rst = 1'b0;
    f_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (f_rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_f_rvalid got %b want 0", f_rvalid);
    end
    tick();
    rst = 1'b1;
    f_req = 1'b1; f_addr = 32'h0;
    @(negedge clk);
`ifdef IMEM_ARB_BOOT_EN
    checks++;
    if (f_gnt !== 1'b0 || pc_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_boot got f=%b s=%b want 0 1", f_gnt, pc_stall);
    end
`else
    checks++;
    if (f_gnt !== 1'b1 || pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_run got f=%b s=%b want 1 0", f_gnt, pc_stall);
    end
    fq.push_back(shadow[0]);
`endif
    tick();
    idle();
  endtask

  task automatic test_drain;
    tick(); tick(); tick();
    checks++;
    if (fq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL drain got f=%0d l=%0d pending want 0 0",
               fq.size(), lq.size());
    end
  endtask

  initial begin
    test_reset();
`ifdef IMEM_ARB_BOOT_EN
    test_loader_write();
    test_boot();
`else
    test_first_fetch();
    test_loader_write();
`endif
    test_starve();
    test_hold();
    test_reset_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width of every address port.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the instruction/data word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, range 1..15, meaning the maximum number of consecutive cycles the loader may wait while in RUN.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 f_req  input  1  fetch unit requests an instruction read.
REQ-007 f_addr  input  ADDR_W  fetch byte address (PC).
REQ-008 f_gnt  output  1  fetch read issued to memory this cycle.
REQ-009 f_rvalid  output  1  f_rdata valid this cycle.
REQ-010 f_rdata  output  DATA_W  fetched instruction.
REQ-011 pc_stall  output  1  fetch unit holds PC this cycle.
REQ-012 l_req  input  1  loader/debug port requests access.
REQ-013 l_we  input  1  loader access is a write.
REQ-014 l_addr  input  ADDR_W  loader byte address.
REQ-015 l_wdata  input  DATA_W  loader write data.
REQ-016 l_gnt  output  1  loader access issued to memory this cycle.
REQ-017 l_rvalid  output  1  l_rdata valid this cycle.
REQ-018 l_rdata  output  DATA_W  loader read data.
REQ-019 boot_done  input  1  single-cycle pulse ending the boot phase.
REQ-020 mem_en, mem_we  output  1 each  memory port enable and write enable.
REQ-021 mem_addr  output  ADDR_W  memory byte address; mem_wdata  output  DATA_W.
REQ-022 mem_rdata  input  DATA_W  memory read data, synchronous, valid the cycle after mem_en with mem_we=0.

Function
REQ-023 The block SHALL implement a two-state FSM, BOOT and RUN; BOOT->RUN on boot_done=1; RUN has no exit except reset.
REQ-024 In BOOT, l_gnt SHALL equal l_req, f_gnt SHALL be 0, and pc_stall SHALL be 1.
REQ-025 In RUN, fetch SHALL win when both request, unless starve_cnt equals STARVE_MAX, in which case the loader SHALL win.
REQ-026 starve_cnt (4 bits) SHALL increment each RUN cycle where l_req=1 and l_gnt=0, clear when l_gnt=1 or l_req=0, and saturate at STARVE_MAX.
REQ-027 At most one of f_gnt and l_gnt SHALL be 1 in any cycle; each grant is combinational from the current requests and state.
REQ-028 pc_stall SHALL equal f_req AND NOT f_gnt in RUN.
REQ-029 Memory outputs SHALL be driven from the granted requester; with no grant, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold the previous value.
REQ-030 f_rvalid/l_rvalid SHALL be registered, asserting exactly one cycle after a granted read (l_we=0 for the loader); loader writes produce no l_rvalid.
REQ-031 f_rdata and l_rdata SHALL both be wired to mem_rdata.
REQ-032 A boot_done pulse arriving together with l_req SHALL still grant the loader that cycle; RUN arbitration starts next cycle.
REQ-033 A boot_done received while already in RUN SHALL be ignored.

Reset
REQ-034 While rst=0, state SHALL be BOOT (RUN without the macro), starve_cnt, f_rvalid, and l_rvalid SHALL be 0, and mem_addr/mem_wdata SHALL be 0.
REQ-035 Reset asserted mid-access SHALL cancel any pending rvalid; no rvalid SHALL appear after rst deasserts until a new grant.

Configuration
REQ-036 With macro IMEM_ARB_BOOT_EN defined, the BOOT state and boot_done behaviour SHALL exist as specified above.
REQ-037 Without IMEM_ARB_BOOT_EN, the FSM SHALL reset directly into RUN, boot_done SHALL be ignored, and no fetch stall SHALL exist beyond REQ-028.

Verification
REQ-038 BOOT_EN; after reset, loader writes 0x00000013 to 0x0, then 0x00400093 to 0x4 -> l_gnt=1 on both cycles, mem_we=1, pc_stall=1, f_gnt=0 throughout.
REQ-039 BOOT_EN; boot_done pulse, then f_req=1 with f_addr=0x4 -> f_gnt=1 on the next cycle, and f_rvalid=1 with f_rdata=0x00400093 one cycle later.
REQ-040 RUN; f_req=1 and l_req=1 (read) held continuously, STARVE_MAX=4 -> 4 fetch grants, then 1 loader grant with pc_stall=1, then repeat; l_rvalid 1 cycle after each loader grant.
REQ-041 RUN; l_req=1 with f_req=0 -> l_gnt=1 immediately, and starve_cnt stays 0.
REQ-042 RUN; rst pulsed low the cycle after a fetch grant -> f_rvalid stays 0, and after release the state is BOOT (RUN without the macro).
REQ-043 Without the macro; f_req=1 in the first cycle after reset -> f_gnt=1, and boot_done=1 has no effect.
